// File: rtl/rm4u_err_sweep.sv
// rm4u_err_sweep: drives every operand pair into a combinational W x W multiplier
// under test, compares its product against the exact product and accumulates
// error statistics (error count, absolute-error sum, signed bias, worst case).
module rm4u_err_sweep #(
  parameter int unsigned W     = 4,
  parameter int unsigned CNT_W = 2*W+1,
  parameter int unsigned SUM_W = 4*W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  output logic [W-1:0]       a_o,
  output logic [W-1:0]       b_o,
  input  logic [2*W-1:0]     mut_p,
  output logic               busy,
  output logic               done,
  output logic [CNT_W-1:0]   err_cnt,
  output logic [SUM_W-1:0]   sum_ed,
  output logic [SUM_W:0]     bias,
  output logic [2*W-1:0]     max_ed,
  output logic [W-1:0]       worst_a,
  output logic [W-1:0]       worst_b
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t state_q, state_d;

  // Pair counter carries one extra bit: it runs to 2^(2W) so the state machine
  // stays in SWEEP for the cycle that captures the final MUT product.
  logic [2*W:0]   cnt;
  logic           v0;          // a_o/b_o hold a pair that belongs to this sweep
  logic           s1_v;
  logic [W-1:0]   s1_a;
  logic [W-1:0]   s1_b;
  logic [2*W-1:0] s1_p;

  logic [2*W-1:0] exact;
  logic [2*W:0]   diff;
  logic [2*W:0]   diff_neg;
  logic [2*W-1:0] ed;

  logic start_ok;
  assign start_ok = (state_q == IDLE) && start;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state and status outputs
  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      IDLE:  if (start) state_d = SWEEP;
      SWEEP: begin
        busy = 1'b1;
        if (cnt[2*W]) state_d = DRAIN;
      end
      DRAIN: begin
        busy    = 1'b1;
        state_d = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Operand generator: {a_o,b_o} walks the counter in A-major order
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      v0  <= 1'b0;
      a_o <= '0;
      b_o <= '0;
    end else if (start_ok) begin
      cnt <= '0;
      v0  <= 1'b0;
    end else if (state_q == SWEEP && !cnt[2*W]) begin
      {a_o, b_o} <= cnt[2*W-1:0];
      cnt        <= cnt + 1'b1;
      v0         <= 1'b1;
    end else begin
      v0 <= 1'b0;
    end
  end

  // Stage 1: capture the pair together with the MUT's product for it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v <= 1'b0;
      s1_a <= '0;
      s1_b <= '0;
      s1_p <= '0;
    end else if (start_ok) begin
      s1_v <= 1'b0;
    end else begin
      s1_v <= v0;
      s1_a <= a_o;
      s1_b <= b_o;
      s1_p <= mut_p;
    end
  end

  // Stage 2 arithmetic: exact product, signed difference, absolute error
  always_comb begin
    exact    = {{W{1'b0}}, s1_a} * {{W{1'b0}}, s1_b};
    diff     = {1'b0, s1_p} - {1'b0, exact};
    diff_neg = '0 - diff;
    ed       = diff[2*W] ? diff_neg[2*W-1:0] : diff[2*W-1:0];
  end

  // Stage 2 accumulation; strict compare keeps the first pair on ties
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt <= '0;
      sum_ed  <= '0;
      bias    <= '0;
      max_ed  <= '0;
      worst_a <= '0;
      worst_b <= '0;
    end else if (start_ok) begin
      err_cnt <= '0;
      sum_ed  <= '0;
      bias    <= '0;
      max_ed  <= '0;
      worst_a <= '0;
      worst_b <= '0;
    end else if (s1_v) begin
      err_cnt <= err_cnt + {{(CNT_W-1){1'b0}}, |ed};
      sum_ed  <= sum_ed + {{(SUM_W-2*W){1'b0}}, ed};
      bias    <= bias + {{(SUM_W-2*W){diff[2*W]}}, diff};
      if (ed > max_ed) begin
        max_ed  <= ed;
        worst_a <= s1_a;
        worst_b <= s1_b;
      end
    end
  end

endmodule

// File: tb/tb_rm4u_err_sweep.sv
// Directed bench for rm4u_err_sweep with a behavioural MUT selectable per test.
module tb_rm4u_err_sweep;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [3:0] a_o, b_o;
  logic [7:0] mut_p;
  logic       busy, done;
  logic [8:0] err_cnt;
  logic [15:0] sum_ed;
  logic [16:0] bias;
  logic [7:0] max_ed;
  logic [3:0] worst_a, worst_b;

  int checks = 0;
  int errors = 0;
  int mode = 0;   // 0 exact, 1 xor LSB, 2 mask bit 7

  rm4u_err_sweep #(.W(4), .CNT_W(9), .SUM_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a_o(a_o), .b_o(b_o),
    .mut_p(mut_p), .busy(busy), .done(done), .err_cnt(err_cnt),
    .sum_ed(sum_ed), .bias(bias), .max_ed(max_ed),
    .worst_a(worst_a), .worst_b(worst_b)
  );

  always #5 clk = ~clk;

  // Behavioural MUT
  logic [7:0] prod;
  always_comb begin
    prod = {4'b0, a_o} * {4'b0, b_o};
    case (mode)
      1:       mut_p = prod ^ 8'h01;
      2:       mut_p = prod & 8'h7F;
      default: mut_p = prod;
    endcase
  end

  // Issue start, then count edges after the start edge; optional extra start
  // pulses are raised right after edges p0/p1/p2. Stops one edge after done.
  task automatic run_sweep(input int p0, input int p1, input int p2,
                           output int done_edge, output int pulses,
                           output logic [7:0] pair1, output logic [7:0] pair2,
                           output int busy_lo);
    int n;
    done_edge = -1; pulses = 0; busy_lo = 0; pair1 = 8'hxx; pair2 = 8'hxx;
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1; start = 1'b0; n = 0;
    while (n < 400) begin
      @(posedge clk); #1; n++; start = 1'b0;
      if (n == p0 || n == p1 || n == p2) start = 1'b1;
      if (n == 1) pair1 = {a_o, b_o};
      if (n == 2) pair2 = {a_o, b_o};
      if (n < 258 && !busy) busy_lo++;
      if (done) begin
        pulses++;
        if (done_edge < 0) done_edge = n;
      end
      if (done_edge >= 0 && n >= done_edge + 1) break;
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({a_o, b_o, busy, done, err_cnt, sum_ed, bias, max_ed, worst_a, worst_b} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got a=%0d b=%0d busy=%0b done=%0b err=%0d sum=%0d bias=%0d max=%0d wa=%0d wb=%0d, expected all 0",
               a_o, b_o, busy, done, err_cnt, sum_ed, bias, max_ed, worst_a, worst_b);
    end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_exact();
    int de, pu, bl; logic [7:0] p1, p2;
    mode = 0;
    run_sweep(-1, -1, -1, de, pu, p1, p2, bl);
    checks++; if (de !== 258) begin errors++; $display("FAIL exact_done_edge: got %0d expected 258", de); end
    checks++; if (pu !== 1) begin errors++; $display("FAIL exact_done_pulses: got %0d expected 1", pu); end
    checks++; if (p1 !== 8'h00 || p2 !== 8'h01) begin errors++; $display("FAIL exact_first_pairs: got %h %h expected 00 01", p1, p2); end
    checks++; if (bl !== 0) begin errors++; $display("FAIL exact_busy: busy low %0d times during sweep expected 0", bl); end
    checks++; if ({a_o, b_o} !== 8'hFF) begin errors++; $display("FAIL exact_last_pair: got %h expected ff", {a_o, b_o}); end
    checks++;
    if (err_cnt !== 0 || sum_ed !== 0 || bias !== 0 || max_ed !== 0 || worst_a !== 0 || worst_b !== 0) begin
      errors++;
      $display("FAIL exact_results: got err=%0d sum=%0d bias=%0d max=%0d w=%0d/%0d expected all 0",
               err_cnt, sum_ed, bias, max_ed, worst_a, worst_b);
    end
  endtask

  task automatic check_xor(input string tag);
    checks++;
    if (err_cnt !== 9'd256 || sum_ed !== 16'd256 || bias !== 17'd128 ||
        max_ed !== 8'd1 || worst_a !== 4'd0 || worst_b !== 4'd0) begin
      errors++;
      $display("FAIL %s: got err=%0d sum=%0d bias=%0d max=%0d w=%0d/%0d expected 256 256 128 1 0/0",
               tag, err_cnt, sum_ed, bias, max_ed, worst_a, worst_b);
    end
  endtask

  task automatic test_xor();
    int de, pu, bl; logic [7:0] p1, p2;
    mode = 1;
    run_sweep(-1, -1, -1, de, pu, p1, p2, bl);
    checks++; if (de !== 258) begin errors++; $display("FAIL xor_done_edge: got %0d expected 258", de); end
    check_xor("xor_results");
    mode = 0;
    repeat (5) @(posedge clk);
    #1;
    check_xor("xor_results_hold");
  endtask

  task automatic test_mask();
    int de, pu, bl; logic [7:0] p1, p2;
    mode = 2;
    run_sweep(-1, -1, -1, de, pu, p1, p2, bl);
    checks++; if (de !== 258) begin errors++; $display("FAIL mask_done_edge: got %0d expected 258", de); end
    checks++;
    if (err_cnt !== 9'd32 || sum_ed !== 16'd4096 || bias !== 17'h1F000 ||
        max_ed !== 8'd128 || worst_a !== 4'd9 || worst_b !== 4'd15) begin
      errors++;
      $display("FAIL mask_results: got err=%0d sum=%0d bias=%h max=%0d w=%0d/%0d expected 32 4096 1f000 128 9/15",
               err_cnt, sum_ed, bias, max_ed, worst_a, worst_b);
    end
  endtask

  task automatic test_start_ignored();
    int de, pu, bl; logic [7:0] p1, p2;
    mode = 1;
    run_sweep(10, 100, 258, de, pu, p1, p2, bl);
    checks++; if (de !== 258 || pu !== 1) begin errors++; $display("FAIL ignore_done: got edge %0d pulses %0d expected 258 1", de, pu); end
    check_xor("ignore_results");
    @(posedge clk); #1;
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL ignore_no_restart: got busy=%0b done=%0b expected 0 0", busy, done); end
  endtask

  task automatic test_reset_mid();
    int de, pu, bl, n, seen; logic [7:0] p1, p2;
    mode = 1;
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (50) @(posedge clk);
    #1; rst_n = 1'b0; #1;
    checks++;
    if ({a_o, b_o, busy, done, err_cnt, sum_ed, bias, max_ed, worst_a, worst_b} !== '0) begin
      errors++;
      $display("FAIL midreset_outputs: got a=%0d b=%0d busy=%0b done=%0b err=%0d sum=%0d bias=%0d max=%0d expected all 0",
               a_o, b_o, busy, done, err_cnt, sum_ed, bias, max_ed);
    end
    @(negedge clk); rst_n = 1'b1;
    seen = 0; n = 0;
    repeat (300) begin
      @(posedge clk); #1; n++;
      if (done || busy) seen++;
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL midreset_idle: got %0d busy/done cycles expected 0", seen); end
    run_sweep(-1, -1, -1, de, pu, p1, p2, bl);
    checks++; if (de !== 258) begin errors++; $display("FAIL midreset_rerun_edge: got %0d expected 258", de); end
    check_xor("midreset_rerun_results");
  endtask

  task automatic test_back_to_back();
    int de, pu, bl; logic [7:0] p1, p2;
    mode = 2;
    run_sweep(-1, -1, -1, de, pu, p1, p2, bl);
    mode = 1;
    run_sweep(-1, -1, -1, de, pu, p1, p2, bl);
    checks++; if (de !== 258 || pu !== 1) begin errors++; $display("FAIL b2b_done: got edge %0d pulses %0d expected 258 1", de, pu); end
    check_xor("b2b_second_results");
  endtask

  initial begin
    test_reset();
    test_exact();
    test_xor();
    test_mask();
    test_start_ignored();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
